// File: rtl/nand_logic_sweeper_if.sv
// Handshake bundle for nand_logic_sweeper: start/op in, sweep status,
// current sample and truth table out. master drives start/op; slave is the DUT.
interface nand_logic_sweeper_if #(
  parameter int N_IN = 2
);
  logic              start;
  logic [2:0]        op;
  logic              busy;
  logic              valid;
  logic [N_IN-1:0]   cur_in;
  logic              cur_out;
  logic              done;
  logic              err;
  logic [2**N_IN-1:0] table_out;

  modport master (
    output start, op,
    input  busy, valid, cur_in, cur_out,
    input  done, err, table_out
  );

  modport slave (
    input  start, op,
    output busy, valid, cur_in, cur_out,
    output done, err, table_out
  );
endinterface

// File: rtl/nand_logic_sweeper.sv
// N-input logic evaluator built from 2-input NAND gates; one start sweeps
// all 2**N_IN input vectors, one per clock, streaming results into a table.
// Ports: clk, rst (sync, active-high), bus.slave (start/op in;
// busy/valid/cur_in/cur_out/done/err/table_out out, all registered).
module nand_logic_sweeper #(
  parameter int N_IN = 2
) (
  input logic                 clk,
  input logic                 rst,
  nand_logic_sweeper_if.slave bus
);
  localparam int W = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N_IN-1:0] cnt, cnt_nx;
  logic [2:0]      op_q, op_nx;
  logic [W-1:0]    tbl, tbl_nx;
  logic            err_q, err_nx;
  logic            busy_q, busy_nx;
  logic            valid_q, valid_nx;
  logic [N_IN-1:0] cin_q, cin_nx;
  logic            cout_q, cout_nx;
  logic            done_q, done_nx;

  // NAND datapath on the current count
  logic [N_IN-1:0] x;
  logic [N_IN-1:0] inv;
  logic nand_all, and_all, or_all, nor_all;
  logic xor_all, xnor_all;
  logic res;

  assign x = cnt;

  for (genvar i = 0; i < N_IN; i++) begin : g_inv
    nand u_inv (inv[i], x[i], x[i]);
  end

  // Each stage folds one more input into the AND, the
  // inverted-input AND (for OR/NOR) and the XOR chains.
  for (genvar i = 1; i < N_IN; i++) begin : g_st
    logic a_in, o_in, p_in;
    logic an, ac, onn, oc;
    logic xm, xa, xb, px;

    if (i == 1) begin : g_first
      assign a_in = x[0];
      assign o_in = inv[0];
      assign p_in = x[0];
    end else begin : g_next
      assign a_in = g_st[i-1].ac;
      assign o_in = g_st[i-1].oc;
      assign p_in = g_st[i-1].px;
    end

    nand u_an (an, a_in, x[i]);
    nand u_ac (ac, an, an);
    nand u_on (onn, o_in, inv[i]);
    nand u_oc (oc, onn, onn);
    nand u_xm (xm, p_in, x[i]);
    nand u_xa (xa, p_in, xm);
    nand u_xb (xb, x[i], xm);
    nand u_xo (px, xa, xb);
  end

  assign nand_all = g_st[N_IN-1].an;
  assign and_all  = g_st[N_IN-1].ac;
  assign or_all   = g_st[N_IN-1].onn;
  assign nor_all  = g_st[N_IN-1].oc;
  assign xor_all  = g_st[N_IN-1].px;

  nand u_xn (xnor_all, xor_all, xor_all);

  always_comb begin
    res = 1'b0;
    unique case (1'b1)
      op_q == 3'd0: res = nand_all;
      op_q == 3'd1: res = and_all;
      op_q == 3'd2: res = or_all;
      op_q == 3'd3: res = nor_all;
      op_q == 3'd4: res = xor_all;
      op_q == 3'd5: res = xnor_all;
      default:      res = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = SWEEP;
      SWEEP:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    cnt_nx   = cnt;
    op_nx    = op_q;
    tbl_nx   = tbl;
    err_nx   = err_q;
    busy_nx  = busy_q;
    valid_nx = valid_q;
    cin_nx   = cin_q;
    cout_nx  = cout_q;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          op_nx   = bus.op;
          cnt_nx  = '0;
          tbl_nx  = '0;
          err_nx  = (bus.op > 3'd5);
          busy_nx = 1'b1;
        end
      end
      SWEEP: begin
        tbl_nx[cnt] = res;
        cin_nx      = cnt;
        cout_nx     = res;
        valid_nx    = 1'b1;
        if (cnt == LAST) done_nx = 1'b1;
        else             cnt_nx  = cnt + 1'b1;
      end
      DONE: begin
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      tbl     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cin_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      op_q    <= op_nx;
      tbl     <= tbl_nx;
      err_q   <= err_nx;
      busy_q  <= busy_nx;
      valid_q <= valid_nx;
      cin_q   <= cin_nx;
      cout_q  <= cout_nx;
      done_q  <= done_nx;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.cur_in    = cin_q;
  assign bus.cur_out   = cout_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.table_out = tbl;
endmodule

// File: tb/tb_nand_logic_sweeper.sv
// Bench for nand_logic_sweeper: N_IN=2 and N_IN=3 instances, vector
// table, hand-written corner sequences and randomized sweeps vs a model.
module tb_nand_logic_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st  [2];
  logic [2:0] opr [2];

  nand_logic_sweeper_if #(.N_IN(2)) if2 ();
  nand_logic_sweeper_if #(.N_IN(3)) if3 ();

  nand_logic_sweeper #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );
  nand_logic_sweeper #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  assign if2.start = st[0];
  assign if2.op    = opr[0];
  assign if3.start = st[1];
  assign if3.op    = opr[1];

  logic         busy  [2];
  logic         valid [2];
  logic         cout  [2];
  logic         done  [2];
  logic         err   [2];
  logic [7:0]   cin   [2];
  logic [255:0] tbl   [2];

  assign busy[0]  = if2.busy;
  assign valid[0] = if2.valid;
  assign cout[0]  = if2.cur_out;
  assign done[0]  = if2.done;
  assign err[0]   = if2.err;
  assign cin[0]   = {6'd0, if2.cur_in};
  assign tbl[0]   = {252'd0, if2.table_out};
  assign busy[1]  = if3.busy;
  assign valid[1] = if3.valid;
  assign cout[1]  = if3.cur_out;
  assign done[1]  = if3.done;
  assign err[1]   = if3.err;
  assign cin[1]   = {5'd0, if3.cur_in};
  assign tbl[1]   = {248'd0, if3.table_out};

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: gate function straight from its truth definition
  function automatic logic mdl(int n, logic [2:0] op, int v);
    int   full;
    logic par;
    full = (1 << n) - 1;
    par  = ($countones(v) % 2) == 1;
    case (op)
      3'd0:    return v != full;
      3'd1:    return v == full;
      3'd2:    return v != 0;
      3'd3:    return v == 0;
      3'd4:    return par;
      3'd5:    return !par;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [255:0] mdl_tbl(int n, logic [2:0] op);
    logic [255:0] t;
    t = '0;
    for (int v = 0; v < (1 << n); v++) t[v] = mdl(n, op, v);
    return t;
  endfunction

  task automatic run_sweep(input int d, input logic [2:0] op,
                           input logic [255:0] etbl, input logic eerr,
                           input bit noise);
    int n;
    int w;
    n = d + 2;
    w = 1 << n;
    @(negedge clk);
    st[d]  = 1'b1;
    opr[d] = op;
    @(posedge clk); #1;
    st[d] = 1'b0;
    chk("acc_busy", busy[d], 1);
    chk("acc_err", err[d], eerr);
    chk("acc_tbl", tbl[d], 0);
    chk("acc_valid", valid[d], 0);
    for (int k = 0; k < w; k++) begin
      if (noise) begin
        st[d]  = 1'($urandom_range(0, 1));
        opr[d] = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      chk("s_valid", valid[d], 1);
      chk("s_in", cin[d], k);
      chk("s_out", cout[d], mdl(n, op, k));
      chk("s_done", done[d], k == w - 1);
      chk("s_busy", busy[d], 1);
    end
    @(posedge clk); #1;
    st[d] = 1'b0;
    chk("end_done", done[d], 0);
    chk("end_valid", valid[d], 0);
    chk("end_busy", busy[d], 0);
    chk("end_tbl", tbl[d], etbl);
    chk("end_err", err[d], eerr);
  endtask

  typedef struct {
    int           d;
    logic [2:0]   op;
    logic [255:0] tbl;
    logic         err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int nd;
    int dd;
    logic [2:0] rop;
    st[0] = 1'b0; st[1] = 1'b0;
    opr[0] = '0; opr[1] = '0;

    vecs[0] = '{0, 3'd2, 256'hE,  1'b0};
    vecs[1] = '{0, 3'd0, 256'h7,  1'b0};
    vecs[2] = '{1, 3'd4, 256'h96, 1'b0};
    vecs[3] = '{0, 3'd1, 256'h8,  1'b0};
    vecs[4] = '{0, 3'd3, 256'h1,  1'b0};
    vecs[5] = '{0, 3'd5, 256'h9,  1'b0};
    vecs[6] = '{0, 3'd7, 256'h0,  1'b1};
    vecs[7] = '{0, 3'd2, 256'hE,  1'b0};
    vecs[8] = '{1, 3'd0, 256'h7F, 1'b0};
    vecs[9] = '{1, 3'd6, 256'h0,  1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_valid", valid[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_err", err[d], 0);
      chk("rst_tbl", tbl[d], 0);
      chk("rst_in", cin[d], 0);
      chk("rst_out", cout[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // start and rst together: rst wins
    @(negedge clk);
    st[0] = 1'b1; opr[0] = 3'd1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_vs_start", busy[0], 0);
    @(negedge clk);
    rst = 1'b0; st[0] = 1'b0;

    for (int i = 0; i < 10; i++)
      run_sweep(vecs[i].d, vecs[i].op, vecs[i].tbl, vecs[i].err, 1'b0);

    // start during sweep is ignored
    @(negedge clk);
    st[0] = 1'b1; opr[0] = 3'd1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    nd = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin
        st[0] = 1'b1; opr[0] = 3'd3;
      end else begin
        st[0] = 1'b0;
      end
      @(posedge clk); #1;
      if (done[0]) nd++;
    end
    chk("ign_ndone", nd, 1);
    chk("ign_tbl", tbl[0], 256'h8);
    chk("ign_busy", busy[0], 0);

    // rst mid-sweep discards the partial table
    @(negedge clk);
    st[0] = 1'b1; opr[0] = 3'd5;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_partial", tbl[0], 256'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_busy", busy[0], 0);
    chk("mid_valid", valid[0], 0);
    chk("mid_tbl", tbl[0], 0);
    chk("mid_in", cin[0], 0);
    chk("mid_out", cout[0], 0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done[0] || busy[0]) nd++;
    end
    chk("mid_nodone", nd, 0);

    // start held high re-triggers right after DONE
    @(negedge clk);
    st[0] = 1'b1; opr[0] = 3'd1;
    @(posedge clk); #1;
    for (int c = 0; c < 20 && !done[0]; c++) begin
      @(posedge clk); #1;
    end
    chk("b2b_done1", done[0], 1);
    @(posedge clk); #1;
    chk("b2b_idle", busy[0], 0);
    @(posedge clk); #1;
    chk("b2b_again", busy[0], 1);
    st[0] = 1'b0;
    for (int c = 0; c < 20 && !done[0]; c++) begin
      @(posedge clk); #1;
    end
    chk("b2b_done2", done[0], 1);
    chk("b2b_tbl", tbl[0], 256'h8);
    @(posedge clk); #1;

    // randomized sweeps, op and start jittered mid-sweep
    for (int i = 0; i < 24; i++) begin
      dd  = int'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      run_sweep(dd, rop, mdl_tbl(dd + 2, rop), rop > 3'd5, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
